// File: rtl/multicycle_adder.sv
// Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock (ripple over NCH chunks).
// Latency: out_valid rises NCH cycles after the accepting edge; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is seen.
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cin_q, carry_q, cout_q, ovf_q;
    logic [KW-1:0]    k_q;
    logic             last_chunk;

    logic [CHUNK-1:0] ch_a, ch_b, ch_s;
    logic             ch_ci, ch_co, top_cin;
    logic [WIDTH-1:0] ch_mask, sum_upd;

    assign last_chunk = (k_q == KW'(NCH - 1));

    // Current chunk's slice of the operands, its addition and the merged sum word.
    always_comb begin
        ch_a          = CHUNK'(a_q >> (k_q * CHUNK));
        ch_b          = CHUNK'(b_q >> (k_q * CHUNK));
        ch_ci         = (k_q == '0) ? cin_q : carry_q;
        {ch_co, ch_s} = {1'b0, ch_a} + {1'b0, ch_b} + (CHUNK + 1)'(ch_ci);
        ch_mask       = ~(WIDTH'({CHUNK{1'b1}}) << (k_q * CHUNK));
        sum_upd       = (sum_q & ch_mask) | (WIDTH'(ch_s) << (k_q * CHUNK));
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
        top_cin       = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ ch_s[CHUNK-1];
    end

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode: accept in IDLE, ripple through chunks in BUSY, hold in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = BUSY;
            BUSY:    if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-chunk accumulation and final flag computation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        cin_q <= cin;
                        k_q   <= '0;
                    end
                end
                BUSY: begin
                    sum_q   <= sum_upd;
                    carry_q <= ch_co;
                    if (last_chunk) begin
                        cout_q <= ch_co;
                        ovf_q  <= top_cin ^ ch_co;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 4: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; NCH = WIDTH/CHUNK.
REQ-003 The module SHALL have one clock and a synchronous, active-low reset.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit: operands a, b, cin present.
REQ-007 The module SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-008 The module SHALL have port a, input, WIDTH bits: addend.
REQ-009 The module SHALL have port b, input, WIDTH bits: addend.
REQ-010 The module SHALL have port cin, input, 1 bit: carry in.
REQ-011 The module SHALL have port out_valid, output, 1 bit: sum, cout and overflow valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-013 The module SHALL have port sum, output, WIDTH bits: (a+b+cin) mod 2^WIDTH.
REQ-014 The module SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-015 The module SHALL have port overflow, output, 1 bit: two's-complement overflow, i.e. carry into bit WIDTH-1 XOR cout.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE; both SHALL be registered-state decodes.
REQ-018 In IDLE, on an edge with in_valid=1, the block SHALL latch a, b and cin into internal registers, clear the chunk index k to 0, and go to BUSY.
REQ-019 In IDLE with in_valid=0, the block SHALL stay in IDLE.
REQ-020 On each BUSY edge, the block SHALL add bits [k*CHUNK+CHUNK-1 : k*CHUNK] of the latched a and b plus the carry register, write the CHUNK-bit result into the same bits of the sum register, store the chunk carry-out in the carry register, and increment k.
REQ-021 Chunk 0 SHALL use the latched cin as its carry in.
REQ-022 On the BUSY edge that processes k = NCH-1, the block SHALL load cout with that chunk's carry-out, load overflow with (carry into bit WIDTH-1) XOR (carry-out), and go to DONE.
REQ-023 Latency: out_valid SHALL rise exactly NCH cycles after the accepting edge.
REQ-024 With CHUNK = WIDTH, BUSY SHALL last one cycle.
REQ-025 In DONE, sum, cout and overflow SHALL be held stable while out_ready=0.
REQ-026 On an edge in DONE with out_ready=1, the block SHALL go to IDLE; in_ready SHALL then be 1 in the following cycle.
REQ-027 No new operand SHALL be accepted in the same cycle as the output handshake.
REQ-028 Changes on a, b, cin or in_valid while in BUSY or DONE SHALL have no effect.
REQ-029 out_ready SHALL be ignored outside DONE.
REQ-030 The carry register SHALL be WIDTH-independent (1 bit); k SHALL be sized to hold 0..NCH-1 without wrap-around before it reaches NCH-1.
REQ-031 sum and cout SHALL wrap modulo 2^WIDTH; no saturation.
REQ-032 Sum bits not yet written in BUSY SHALL retain their previous values; they are don't-care because out_valid=0.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL go to IDLE and clear k, the carry register, sum, cout and overflow to 0.
REQ-034 Immediately after such a reset edge, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-035 A reset asserted in BUSY or DONE SHALL abort the operation; its result SHALL never be presented.
REQ-036 Reset SHALL take priority over every other event in the same cycle.
REQ-037 Reset SHALL have no asynchronous effect.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-038 The bench SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0, with out_valid exactly 4 cycles after the accept edge.
REQ-039 The bench SHALL cover: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1.
REQ-040 The bench SHALL cover: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, overflow=0; and a, b toggled randomly during BUSY -> same result.
REQ-041 The bench SHALL cover: out_ready held 0 for 3 cycles in DONE -> sum, cout, overflow and out_valid=1 stable, in_ready=0; with out_ready=1 -> IDLE, and in_ready=1 on the next cycle.
REQ-042 The bench SHALL cover: rst_n=0 for one edge during the 2nd BUSY cycle -> out_valid=0, in_ready=1, sum=0 next cycle; no stale result is ever presented.
REQ-043 The bench SHALL cover: a CHUNK=16 instance with 1000 random back-to-back transactions and a random out_ready -> every result matches a+b+cin, with a 1-cycle BUSY.
